// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI arbiter: FSM encoding, requester cfg field
// layout and watchdog constants. The optional WAIT watchdog is enabled by
// defining SPI_ARB_TIMEOUT_EN.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_e;

  localparam int WORD_W = 16;

  // Per-requester cfg word: {divide[2:0], polarity, phase, direction}
  localparam int CFG_W         = 6;
  localparam int CFG_DIR_BIT   = 0;
  localparam int CFG_PHASE_BIT = 1;
  localparam int CFG_POL_BIT   = 2;
  localparam int CFG_DIV_LSB   = 3;
  localparam int CFG_DIV_W     = 3;

  // Wide enough for the largest chip-select setup/gap count
  localparam int GAP_CNT_W = 8;

  // Watchdog gives up after this many WAIT cycles
  localparam logic [15:0] WD_LIMIT        = 16'hFFFF;
  localparam logic [15:0] TIMEOUT_RX_WORD = 16'hFFFF;

  function automatic logic [CFG_DIV_W-1:0] cfg_divide(input logic [CFG_W-1:0] cfg);
    return cfg[CFG_DIV_LSB +: CFG_DIV_W];
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Bus between the arbiter and the shared spi_master. The arbiter side uses
// the master modport, the spi_master (or its model) uses the slave modport.
interface spi_arbiter_if;
  logic [15:0] m_tx_data;
  logic        m_tx_start_str;
  logic [2:0]  m_freq_divide;
  logic        m_polarity;
  logic        m_phase;
  logic        m_direction;
  logic [15:0] m_rx_data;
  logic        m_tx_done_str;
  logic        m_busy;

  modport master (
    output m_tx_data, m_tx_start_str, m_freq_divide, m_polarity, m_phase, m_direction,
    input  m_rx_data, m_tx_done_str, m_busy
  );

  modport slave (
    input  m_tx_data, m_tx_start_str, m_freq_divide, m_polarity, m_phase, m_direction,
    output m_rx_data, m_tx_done_str, m_busy
  );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin selector: picks the first active request
// starting one position after last_grant, wrapping around.
module spi_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               valid
);

  logic [NUM_REQ-1:0] rot_s;
  int                 pos_s;
  int                 sum_s;

  // Rotate requests so bit 0 is the highest-priority position, find the first set bit
  always_comb begin
    rot_s = NUM_REQ'({req, req} >> (int'(last_grant) + 1));
    pos_s = 0;
    valid = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        pos_s = j;
        valid = 1'b1;
      end else begin
        pos_s = pos_s;
      end
    end
    sum_s = int'(last_grant) + 1 + pos_s;
    if (sum_s >= NUM_REQ) begin
      sum_s = sum_s - NUM_REQ;
    end else begin
      sum_s = sum_s;
    end
    grant = IDX_W'(sum_s);
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master between NUM_REQ requesters.
// Each frame: grant and latch cfg/data, hold chip select for CS_GAP cycles,
// start the master, wait for completion, then keep all selects high for
// CS_GAP cycles. Define SPI_ARB_TIMEOUT_EN to add a WAIT watchdog and the
// sticky timeout_err output.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CS_GAP  = 4
) (
  input  logic                      clk,
  input  logic                      resetf,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [WORD_W*NUM_REQ-1:0] req_tx_data,
  input  logic [CFG_W*NUM_REQ-1:0]  req_cfg,
  output logic [NUM_REQ-1:0]        done_str,
  output logic [WORD_W-1:0]         rx_word,
  output logic [NUM_REQ-1:0]        cs_n,
  output logic                      arb_busy,
  spi_arbiter_if.master             m_if
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  localparam int                   IDX_W    = $clog2(NUM_REQ);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(CS_GAP - 1);
  localparam logic [IDX_W-1:0]     LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [GAP_CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [WORD_W-1:0]    tx_data_q, tx_data_d;
  logic [CFG_W-1:0]     cfg_q, cfg_d;
  logic                 start_q, start_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [WORD_W-1:0]    rx_word_q, rx_word_d;
  logic [NUM_REQ-1:0]   cs_n_q, cs_n_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   sel_s;
  logic [IDX_W-1:0]     rr_grant_s;
  logic                 rr_valid_s;
  logic [WORD_W-1:0]    data_arr_s [NUM_REQ];
  logic [CFG_W-1:0]     cfg_arr_s  [NUM_REQ];
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0]          wd_q, wd_d;
  logic                 to_err_q, to_err_d;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr_s[i] = req_tx_data[WORD_W*i +: WORD_W];
    assign cfg_arr_s[i]  = req_cfg[CFG_W*i +: CFG_W];
  end

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (rr_grant_s),
    .valid      (rr_valid_s)
  );

  // Next-state and registered-output logic of the frame sequencer
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_data_d    = tx_data_q;
    cfg_d        = cfg_q;
    start_d      = 1'b0;
    done_d       = '0;
    rx_word_d    = rx_word_q;
    cs_n_d       = cs_n_q;
    sel_s        = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    to_err_d     = to_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rr_valid_s) begin
          sel_s[rr_grant_s] = 1'b1;
          grant_d      = rr_grant_s;
          last_grant_d = rr_grant_s;
          tx_data_d    = data_arr_s[rr_grant_s];
          cfg_d        = cfg_arr_s[rr_grant_s];
          cnt_d        = '0;
          cs_n_d       = ~sel_s;
          state_d      = ST_SETUP;
        end else begin
          cs_n_d = '1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_START: begin
        if (!m_if.m_busy) begin
          start_d = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_START;
        end
      end
      ST_WAIT: begin
        if (m_if.m_tx_done_str) begin
          rx_word_d        = m_if.m_rx_data;
          done_d[grant_q]  = 1'b1;
          cs_n_d           = '1;
          cnt_d            = '0;
          state_d          = ST_GAP;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wd_q == WD_LIMIT - 16'd1) begin
          rx_word_d        = TIMEOUT_RX_WORD;
          done_d[grant_q]  = 1'b1;
          to_err_d         = 1'b1;
          cs_n_d           = '1;
          cnt_d            = '0;
          state_d          = ST_GAP;
        end
`endif
        else begin
          state_d = ST_WAIT;
        end
      end
      ST_GAP: begin
        cs_n_d = '1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cs_n_d  = '1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Watchdog counts consecutive WAIT cycles, cleared whenever WAIT is left or entered
  always_comb begin
    if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
      wd_d = wd_q + 16'd1;
    end else begin
      wd_d = 16'd0;
    end
  end
`endif

  // State and output registers; reset releases all chip selects immediately
  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      tx_data_q    <= '0;
      cfg_q        <= '0;
      start_q      <= 1'b0;
      done_q       <= '0;
      rx_word_q    <= '0;
      cs_n_q       <= '1;
      busy_q       <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q         <= '0;
      to_err_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      cfg_q        <= cfg_d;
      start_q      <= start_d;
      done_q       <= done_d;
      rx_word_q    <= rx_word_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q         <= wd_d;
      to_err_q     <= to_err_d;
`endif
    end
  end

  assign done_str              = done_q;
  assign rx_word               = rx_word_q;
  assign cs_n                  = cs_n_q;
  assign arb_busy              = busy_q;
  assign m_if.m_tx_data        = tx_data_q;
  assign m_if.m_tx_start_str   = start_q;
  assign m_if.m_freq_divide    = cfg_divide(cfg_q);
  assign m_if.m_polarity       = cfg_q[CFG_POL_BIT];
  assign m_if.m_phase          = cfg_q[CFG_PHASE_BIT];
  assign m_if.m_direction      = cfg_q[CFG_DIR_BIT];
`ifdef SPI_ARB_TIMEOUT_EN
  assign timeout_err           = to_err_q;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: a spi_master model answers start
// pulses, a scoreboard queue holds the expected frame order and contents.
module tb_spi_arbiter;

  localparam int NR = 4;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          resetf = 1'b0;
  logic [NR-1:0] req = '0;
  logic [16*NR-1:0] req_tx_data = '0;
  logic [6*NR-1:0]  req_cfg = '0;
  logic [NR-1:0] done_str;
  logic [15:0]   rx_word;
  logic [NR-1:0] cs_n;
  logic          arb_busy;
`ifdef SPI_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  spi_arbiter_if sif();

  spi_arbiter #(.NUM_REQ(NR), .CS_GAP(GAP)) dut (
    .clk         (clk),
    .resetf      (resetf),
    .req         (req),
    .req_tx_data (req_tx_data),
    .req_cfg     (req_cfg),
    .done_str    (done_str),
    .rx_word     (rx_word),
    .cs_n        (cs_n),
    .arb_busy    (arb_busy),
    .m_if        (sif.master)
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic [5:0]  cfg;
    logic [15:0] rx;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int hi_run = 0;
  bit had_frame = 1'b0;

  bit busy_force = 1'b0;
  bit tie_done_low = 1'b0;
  bit busy_m = 1'b0;
  int lat_m = 0;
  logic [15:0] cap_m = '0;

  function automatic logic [15:0] miso_pat(input logic [15:0] d);
    return {d[7:0], d[15:8]} ^ 16'h5A5A;
  endfunction

  // spi_master model: busy after a start, done pulse with a data-derived MISO word
  initial begin
    sif.m_busy = 1'b0;
    sif.m_tx_done_str = 1'b0;
    sif.m_rx_data = 16'h0000;
    forever begin
      @(posedge clk); #1;
      sif.m_tx_done_str = 1'b0;
      if (!resetf) begin
        busy_m = 1'b0;
      end else if (busy_m) begin
        if (lat_m == 0) begin
          if (!tie_done_low) begin
            sif.m_tx_done_str = 1'b1;
            sif.m_rx_data = miso_pat(cap_m);
            busy_m = 1'b0;
          end
        end else begin
          lat_m--;
        end
      end else if (sif.m_tx_start_str) begin
        busy_m = 1'b1;
        cap_m = sif.m_tx_data;
        lat_m = 4 + 2 * int'(sif.m_freq_divide);
      end
      sif.m_busy = busy_m | busy_force;
    end
  end

  // Monitor: cs_n legality, deselect gap, start contents and done scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] oh;
    if (!resetf) begin
      hi_run = 0;
      had_frame = 1'b0;
    end else begin
      checks++;
      if ($countones(~cs_n) > 1) begin
        errors++;
        $display("FAIL cs_onehot: cs_n=%b required one-hot-low or all high", cs_n);
      end
      if (cs_n == 4'b1111) begin
        hi_run++;
      end else begin
        if (hi_run > 0 && had_frame) begin
          checks++;
          if (hi_run < GAP) begin
            errors++;
            $display("FAIL cs_gap: high for %0d cycles, required >= %0d", hi_run, GAP);
          end
        end
        hi_run = 0;
      end
      if (sif.m_tx_start_str) begin
        start_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL start_unexpected: start pulse with empty scoreboard");
        end else begin
          e = exp_q[0];
          oh = 4'b0001 << e.idx;
          if (cs_n !== ~oh || sif.m_tx_data !== e.data ||
              {sif.m_freq_divide, sif.m_polarity, sif.m_phase, sif.m_direction} !== e.cfg) begin
            errors++;
            $display("FAIL start_fields: cs_n=%b data=%h cfg=%b, required cs_n=%b data=%h cfg=%b",
                     cs_n, sif.m_tx_data,
                     {sif.m_freq_divide, sif.m_polarity, sif.m_phase, sif.m_direction},
                     ~oh, e.data, e.cfg);
          end
        end
      end
      if (done_str != 4'b0000) begin
        done_cnt++;
        had_frame = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done_str=%b with empty scoreboard", done_str);
        end else begin
          e = exp_q.pop_front();
          oh = 4'b0001 << e.idx;
          if (done_str !== oh || rx_word !== e.rx || sif.m_tx_data !== e.data) begin
            errors++;
            $display("FAIL done_fields: done_str=%b rx=%h data=%h, required done_str=%b rx=%h data=%h",
                     done_str, rx_word, sif.m_tx_data, oh, e.rx, e.data);
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [15:0] d, input logic [5:0] c);
    req_tx_data[16*i +: 16] = d;
    req_cfg[6*i +: 6] = c;
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.idx = i;
    e.data = req_tx_data[16*i +: 16];
    e.cfg = req_cfg[6*i +: 6];
    e.rx = miso_pat(e.data);
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int n, input int bound, output bit ok);
    int tgt;
    tgt = done_cnt + n;
    for (int c = 0; c < bound && done_cnt < tgt; c++) begin
      @(negedge clk); #1;
    end
    ok = (done_cnt >= tgt);
  endtask

  task automatic wait_idle(output bit ok);
    for (int c = 0; c < 100 && arb_busy; c++) begin
      @(negedge clk); #1;
    end
    ok = !arb_busy;
  endtask

  task automatic test_reset();
    resetf = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cs_n !== 4'b1111 || done_str !== 4'b0000 || rx_word !== 16'h0000 || arb_busy !== 1'b0 ||
        sif.m_tx_start_str !== 1'b0 || sif.m_tx_data !== 16'h0000 || sif.m_freq_divide !== 3'b000 ||
        sif.m_polarity !== 1'b0 || sif.m_phase !== 1'b0 || sif.m_direction !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cs_n=%b done=%b rx=%h busy=%b start=%b data=%h div=%b pol/ph/dir=%b%b%b, required all idle/zero",
               cs_n, done_str, rx_word, arb_busy, sif.m_tx_start_str, sif.m_tx_data,
               sif.m_freq_divide, sif.m_polarity, sif.m_phase, sif.m_direction);
    end
    resetf = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_round_robin();
    bit ok;
    for (int i = 0; i < NR; i++) begin
      set_req(i, 16'h1234 + 16'(i * 16'h1111), {3'(i + 1), 1'(i), 1'(i >> 1), ~1'(i)});
    end
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    req = 4'b1111;
    wait_done(5, 400, ok);
    req = 4'b0000;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_done_count: saw %0d frames, required 5", done_cnt);
    end
    wait_idle(ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: busy=%b pending=%0d, required busy=0 pending=0", arb_busy, exp_q.size());
    end
  endtask

  task automatic test_single();
    bit ok;
    int n;
    int low;
    int d0;
    set_req(0, 16'hA5C3, 6'b001_0_0_0);
    push_exp(0);
    d0 = done_cnt;
    req = 4'b0001;
    n = 0;
    low = 0;
    while (n < 50) begin
      @(posedge clk); #1;
      n++;
      if (sif.m_tx_start_str) break;
      if (cs_n[0] == 1'b0) low++;
    end
    checks++;
    if (n != GAP + 2) begin
      errors++;
      $display("FAIL single_latency: start after %0d cycles, required %0d", n, GAP + 2);
    end
    checks++;
    if (low < GAP || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_cs_setup: cs_n[0] low %0d cycles busy=%b, required >= %0d busy=1", low, arb_busy, GAP);
    end
    wait_done(1, 100, ok);
    req = 4'b0000;
    wait_idle(ok);
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || rx_word !== miso_pat(16'hA5C3)) begin
      errors++;
      $display("FAIL single_done: pulses=%0d rx=%h, required 1 rx=%h", done_cnt - d0, rx_word, miso_pat(16'hA5C3));
    end
  endtask

  task automatic test_mid_frame();
    bit ok;
    int s0;
    set_req(1, 16'hBEEF, 6'b010_1_0_1);
    set_req(2, 16'h0F0F, 6'b000_0_1_1);
    push_exp(1);
    s0 = start_cnt;
    req = 4'b0010;
    for (int c = 0; c < 50 && start_cnt == s0; c++) begin
      @(negedge clk); #1;
    end
    set_req(1, 16'h5555, 6'b111_0_1_0);
    req = 4'b0100;
    push_exp(2);
    wait_done(2, 200, ok);
    req = 4'b0000;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_frame_done: frames=%0d pending=%0d, required pending 0", done_cnt, exp_q.size());
    end
    wait_idle(ok);
  endtask

  task automatic test_busy_hold();
    bit ok;
    int s0;
    busy_force = 1'b1;
    repeat (2) @(negedge clk);
    set_req(3, 16'hC001, 6'b011_1_1_0);
    push_exp(3);
    s0 = start_cnt;
    req = 4'b1000;
    repeat (GAP + 10) @(negedge clk);
    checks++;
    if (start_cnt != s0 || arb_busy !== 1'b1 || cs_n !== 4'b0111) begin
      errors++;
      $display("FAIL busy_hold: starts=%0d busy=%b cs_n=%b, required starts=%0d busy=1 cs_n=0111",
               start_cnt - s0, arb_busy, cs_n, 0);
    end
    busy_force = 1'b0;
    wait_done(1, 100, ok);
    req = 4'b0000;
    checks++;
    if (!ok || start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL busy_release: starts=%0d done_ok=%b, required 1 and 1", start_cnt - s0, ok);
    end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back();
    bit ok;
    set_req(0, 16'h1111, 6'b000_0_0_0);
    set_req(1, 16'h2222, 6'b100_1_1_1);
    push_exp(0); push_exp(1); push_exp(0); push_exp(1);
    req = 4'b0011;
    wait_done(4, 300, ok);
    req = 4'b0000;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_done_count: pending=%0d, required 0", exp_q.size());
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int s0;
    set_req(1, 16'h7E57, 6'b001_0_1_0);
    push_exp(1);
    s0 = start_cnt;
    req = 4'b0010;
    for (int c = 0; c < 50 && start_cnt == s0; c++) begin
      @(negedge clk); #1;
    end
    resetf = 1'b0;
    #1;
    checks++;
    if (cs_n !== 4'b1111 || arb_busy !== 1'b0 || done_str !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: cs_n=%b busy=%b done=%b, required 1111 0 0000", cs_n, arb_busy, done_str);
    end
    exp_q.delete();
    set_req(0, 16'h0A0A, 6'b010_0_0_1);
    req = 4'b0111;
    repeat (3) @(negedge clk);
    push_exp(0);
    resetf = 1'b1;
    wait_done(1, 100, ok);
    req = 4'b0000;
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_next_grant: done_ok=%b pending=%0d, required 1 and 0", ok, exp_q.size());
    end
    wait_idle(ok);
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    exp_t e;
    tie_done_low = 1'b1;
    set_req(0, 16'h3C3C, 6'b000_0_0_0);
    e.idx = 0; e.data = 16'h3C3C; e.cfg = 6'b000_0_0_0; e.rx = 16'hFFFF;
    exp_q.push_back(e);
    req = 4'b0001;
    wait_done(1, 70000, ok);
    req = 4'b0000;
    checks++;
    if (!ok || timeout_err !== 1'b1 || rx_word !== 16'hFFFF) begin
      errors++;
      $display("FAIL timeout: done_ok=%b err=%b rx=%h, required 1 1 ffff", ok, timeout_err, rx_word);
    end
    tie_done_low = 1'b0;
    resetf = 1'b0;
    repeat (2) @(negedge clk);
    resetf = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_mid_frame();
    test_busy_hold();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one spi_master (legal range 2..8).
REQ-002 SHALL have parameter CS_GAP, default 4, clk cycles of chip-select setup before a frame and deselect gap after it (legal range 2..255).
REQ-003 SHALL have port clk  in  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port resetf  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  in  NUM_REQ  per-requester transfer request; level, held until that requester's done pulse.
REQ-006 SHALL have port req_tx_data  in  16*NUM_REQ  per-requester word; requester i at bits [16i+15:16i].
REQ-007 SHALL have port req_cfg  in  6*NUM_REQ  per-requester {divide[2:0], polarity, phase, direction} at [6i+5:6i].
REQ-008 SHALL have port done_str  out  NUM_REQ  one-cycle pulse to the granted requester at frame completion.
REQ-009 SHALL have port rx_word  out  16  last received word, valid from the done_str pulse until the next done_str.
REQ-010 SHALL have port cs_n  out  NUM_REQ  active-low chip selects, one-hot-low or all high.
REQ-011 SHALL have port arb_busy  out  1  high in every state except IDLE.
REQ-012 SHALL have ports m_tx_data(16), m_tx_start_str(1), m_freq_divide(3), m_polarity(1), m_phase(1), m_direction(1) out, and m_rx_data(16), m_tx_done_str(1), m_busy(1) in, wired to spi_master.

Function
REQ-013 SHALL implement states IDLE, SETUP, START, WAIT, GAP.
REQ-014 IDLE: when any req is high, SHALL grant one requester, latch its data and cfg, and enter SETUP the next cycle.
REQ-015 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; after reset last_grant = NUM_REQ-1, so requester 0 has first priority.
REQ-016 SETUP: SHALL drive the latched cfg and data on the m_* ports, assert the granted cs_n low, count CS_GAP cycles, then enter START.
REQ-017 START: SHALL pulse m_tx_start_str for exactly one cycle, only when m_busy is low; otherwise it SHALL hold in START.
REQ-018 WAIT: on m_tx_done_str SHALL register m_rx_data into rx_word, pulse done_str[grant] in the same registered cycle, and enter GAP.
REQ-019 GAP: SHALL deassert all cs_n, count CS_GAP cycles, then return to IDLE, so back-to-back frames are separated by at least CS_GAP cycles of cs_n high.
REQ-020 m_* cfg and data outputs SHALL remain stable from SETUP entry through WAIT exit; a requester's cfg changes mid-frame SHALL be ignored.
REQ-021 If req[grant] drops mid-frame, the frame SHALL complete normally and done_str SHALL still pulse.
REQ-022 A requester still holding req after its done_str SHALL rejoin arbitration at normal round-robin priority and gain no extra priority.
REQ-023 Minimum latency from req rising in IDLE to m_tx_start_str SHALL be CS_GAP+2 cycles.

Reset
REQ-024 While resetf is low SHALL force state=IDLE, cs_n=all ones, done_str=0, m_tx_start_str=0, rx_word=0, arb_busy=0, m_* data=0, m_freq_divide=0, m_polarity=0, m_phase=0, m_direction=0, last_grant=NUM_REQ-1.
REQ-025 Reset asserted mid-frame SHALL release cs_n asynchronously and SHALL emit no done_str after reset is released.

Configuration
REQ-026 With SPI_ARB_TIMEOUT_EN defined, a 16-bit watchdog SHALL count WAIT cycles; at 65535 cycles it SHALL pulse done_str[grant] with rx_word=16'hFFFF, set output timeout_err (1 bit, sticky until reset), and enter GAP.
REQ-027 Without SPI_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, and neither the timeout_err port nor the counter SHALL exist.

Structure
REQ-028 The shared package spi_arb_pkg SHALL hold state encodings, the cfg field offsets and widths, and the watchdog limit constant.
REQ-029 The round-robin grant logic SHALL be one sub-module, spi_rr_arbiter (inputs req and last_grant; outputs grant index and a valid flag).

Verification
REQ-030 req=4'b0001, data 16'hA5C3, cfg divide=3'b001 -> cs_n[0] low CS_GAP cycles before the start pulse, m_tx_data=A5C3, done_str[0] pulses once, rx_word equals the MISO pattern.
REQ-031 req=4'b1111 held continuously -> grants follow the order 0,1,2,3,0, with at least CS_GAP cycles of cs_n all high between frames.
REQ-032 req[2] raised during WAIT of requester 1, and req[1] dropped mid-frame -> frame 1 completes, done_str[1] pulses, requester 2 is granted next.
REQ-033 resetf pulsed low during WAIT -> cs_n=4'b1111 immediately, no done_str afterwards, and the next grant goes to requester 0.
REQ-034 SPI_ARB_TIMEOUT_EN defined and m_tx_done_str tied low -> after 65535 WAIT cycles, done_str pulses, rx_word=FFFF, timeout_err=1.
